// File: rtl/d_reg_bank_if.sv
// Bus bundle for d_reg_bank: parallel/serial data in, registered channel state out.
// The widths must match the parameters of the d_reg_bank instance the bundle is bound to.
interface d_reg_bank_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8
);
  logic [CHANNELS*WIDTH-1:0] D;
  logic [CHANNELS-1:0]       EN;
  logic [1:0]                MODE;
  logic                      SIN;
  logic [CHANNELS*WIDTH-1:0] Q;
  logic                      SOUT;
  logic [CHANNELS-1:0]       CHG;
  logic [CNT_W-1:0]          LOAD_CNT;

  modport master (
    output D, EN, MODE, SIN,
    input  Q, SOUT, CHG, LOAD_CNT
  );

  modport slave (
    input  D, EN, MODE, SIN,
    output Q, SOUT, CHG, LOAD_CNT
  );
endinterface

// File: rtl/d_reg_bank.sv
// Bank of CHANNELS enabled WIDTH-bit registers with shared hold/load/shift/clear mode.
// 1-cycle latency from sampled inputs to Q; no backpressure, every enabled edge acts.
module d_reg_bank #(
  parameter int               WIDTH     = 4,
  parameter int               CHANNELS  = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  d_reg_bank_if.slave io_bus
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_SHIFT = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

  localparam int              QW      = CHANNELS * WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [QW-1:0]       r_q;
  logic [CHANNELS-1:0] r_chg;
  logic [CNT_W-1:0]    r_load_cnt;

  logic [QW-1:0]       w_q_nxt;
  logic [CHANNELS-1:0] w_chg_nxt;
  logic                w_load_evt;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [WIDTH-1:0] w_cur;
    logic [WIDTH-1:0] w_new;
    logic [WIDTH-1:0] w_shifted;
    logic             w_sin;

    assign w_cur = r_q[gi*WIDTH +: WIDTH];

    // The chain taps the pre-edge MSB of the previous channel even when that channel is disabled.
    if (gi == 0) begin : g_head
      assign w_sin = io_bus.SIN;
    end else begin : g_link
      assign w_sin = r_q[gi*WIDTH-1];
    end

    always_comb begin
      w_shifted    = w_cur << 1;
      w_shifted[0] = w_sin;
    end

    always_comb begin
      w_new = w_cur;
      if (io_bus.EN[gi]) begin
        case (io_bus.MODE)
          MODE_HOLD:  w_new = w_cur;
          MODE_LOAD:  w_new = io_bus.D[gi*WIDTH +: WIDTH];
          MODE_SHIFT: w_new = w_shifted;
          MODE_CLEAR: w_new = RESET_VAL;
          default:    w_new = w_cur;
        endcase
      end
    end

    assign w_q_nxt[gi*WIDTH +: WIDTH] = w_new;
    assign w_chg_nxt[gi]              = (w_new != w_cur);
  end

  assign w_load_evt = (io_bus.MODE == MODE_LOAD) && (|io_bus.EN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q        <= {CHANNELS{RESET_VAL}};
      r_chg      <= '0;
      r_load_cnt <= '0;
    end else begin
      r_q   <= w_q_nxt;
      r_chg <= w_chg_nxt;
      if (w_load_evt && (r_load_cnt != CNT_MAX)) begin
        r_load_cnt <= r_load_cnt + 1'b1;
      end
    end
  end

  assign io_bus.Q        = r_q;
  assign io_bus.SOUT     = r_q[QW-1];
  assign io_bus.CHG      = r_chg;
  assign io_bus.LOAD_CNT = r_load_cnt;

endmodule

// File: tb/tb_d_reg_bank.sv
// Directed bench for d_reg_bank (WIDTH=4, CHANNELS=2, RESET_VAL=0, CNT_W=2).
// An arithmetic model is compared every cycle; literal expectations pin the model.
module tb_d_reg_bank;
  localparam int W  = 4;
  localparam int C  = 2;
  localparam int CW = 2;
  localparam int CNT_SAT = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  d_reg_bank_if #(.WIDTH(W), .CHANNELS(C), .CNT_W(CW)) bus ();

  d_reg_bank #(
    .WIDTH    (W),
    .CHANNELS (C),
    .RESET_VAL(4'h0),
    .CNT_W    (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  int mq[C];
  int mchg[C];
  int mcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: channel values as integers, shift as multiply-by-two modulo 2^W.
  always @(posedge clk or negedge rst_n) begin
    int old[C];
    int nv;
    int s;
    if (!rst_n) begin
      for (int i = 0; i < C; i++) begin
        mq[i]   = 0;
        mchg[i] = 0;
      end
      mcnt = 0;
    end else begin
      for (int i = 0; i < C; i++) old[i] = mq[i];
      for (int i = 0; i < C; i++) begin
        nv = old[i];
        if (bus.EN[i]) begin
          case (bus.MODE)
            2'b01: nv = int'(bus.D[i*W +: W]);
            2'b10: begin
              if (i == 0) s = int'(bus.SIN);
              else        s = (old[i-1] >> (W - 1)) & 1;
              nv = ((old[i] * 2) % (1 << W)) + s;
            end
            2'b11: nv = 0;
            default: nv = old[i];
          endcase
        end
        mchg[i] = (nv != old[i]) ? 1 : 0;
        mq[i]   = nv;
      end
      if (bus.MODE == 2'b01 && bus.EN != '0 && mcnt < CNT_SAT) mcnt++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_q",    32'(bus.Q),        32'(mq[1] * 16 + mq[0]));
      chk("model_chg",  32'(bus.CHG),      32'(mchg[1] * 2 + mchg[0]));
      chk("model_cnt",  32'(bus.LOAD_CNT), 32'(mcnt));
      chk("model_sout", 32'(bus.SOUT),     32'((mq[1] >> (W - 1)) & 1));
    end
  end

  task automatic cyc(input logic [1:0] en, input logic [1:0] mode,
                     input logic [7:0] d, input logic sin);
    @(negedge clk);
    #1;
    bus.EN   = en;
    bus.MODE = mode;
    bus.D    = d;
    bus.SIN  = sin;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [7:0] q,
                     input logic [1:0] chg, input logic [1:0] cnt);
    chk($sformatf("%s_q", name),   32'(bus.Q),        32'(q));
    chk($sformatf("%s_chg", name), 32'(bus.CHG),      32'(chg));
    chk($sformatf("%s_cnt", name), 32'(bus.LOAD_CNT), 32'(cnt));
  endtask

  initial begin
    bus.EN   = '0;
    bus.MODE = 2'b00;
    bus.D    = '0;
    bus.SIN  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    lit("in_reset", 8'h00, 2'b00, 2'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    #1;
    lit("post_reset", 8'h00, 2'b00, 2'd0);

    // No enables: load must not touch state or the counter.
    repeat (3) begin
      cyc(2'b00, 2'b01, 8'hFF, 1'b0);
      lit("en0_load", 8'h00, 2'b00, 2'd0);
    end

    cyc(2'b01, 2'b01, 8'h3C, 1'b0);
    lit("load_ch0", 8'h0C, 2'b01, 2'd1);
    cyc(2'b01, 2'b01, 8'h3C, 1'b0);
    lit("load_same", 8'h0C, 2'b00, 2'd2);

    cyc(2'b01, 2'b01, 8'h08, 1'b0);
    lit("load_08", 8'h08, 2'b01, 2'd3);
    cyc(2'b11, 2'b10, 8'h00, 1'b1);
    lit("shift_sin1", 8'h11, 2'b11, 2'd3);
    chk("shift_sin1_sout", 32'(bus.SOUT), 32'd0);
    cyc(2'b11, 2'b10, 8'h00, 1'b0);
    lit("shift_sin0", 8'h22, 2'b11, 2'd3);

    cyc(2'b11, 2'b00, 8'hFF, 1'b1);
    lit("hold", 8'h22, 2'b00, 2'd3);
    cyc(2'b00, 2'b11, 8'h00, 1'b0);
    lit("clear_en0", 8'h22, 2'b00, 2'd3);

    // Asynchronous reset between edges.
    cyc(2'b11, 2'b01, 8'hA5, 1'b0);
    lit("load_a5", 8'hA5, 2'b11, 2'd3);
    chk("load_a5_sout", 32'(bus.SOUT), 32'd1);
    #1;
    rst_n  = 1'b0;
    bus.EN = 2'b00;
    #1;
    lit("async_rst", 8'h00, 2'b00, 2'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    for (int k = 0; k < 5; k++) begin
      cyc(2'b10, 2'b01, 8'h70, 1'b0);
      lit("sat", 8'h70, (k == 0) ? 2'b10 : 2'b00, (k < 3) ? 2'(k + 1) : 2'd3);
    end
    cyc(2'b10, 2'b11, 8'h70, 1'b0);
    lit("clear_ch1", 8'h00, 2'b10, 2'd3);

    cyc(2'b11, 2'b01, 8'h88, 1'b0);
    lit("load_88", 8'h88, 2'b11, 2'd3);
    cyc(2'b10, 2'b10, 8'h00, 1'b0);
    lit("shift_ch1_only", 8'h18, 2'b10, 2'd3);
    cyc(2'b11, 2'b10, 8'h00, 1'b1);
    lit("shift_both", 8'h31, 2'b11, 2'd3);

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, limit 20000 reached");
    $fatal(1);
  end
endmodule
